// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit feeding the HI/LO registers.
// A single shift-add (MULT) or restoring-division (DIV) step runs per cycle on
// operand magnitudes. A final FIX cycle applies the sign correction and loads hi/lo.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   start          request, sampled only while idle
//   op             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b           multiplicand/dividend, multiplier/divisor
//   hi, lo         MULT: product high/low half; DIV: remainder/quotient
//   busy           operation in flight
//   ready          one-cycle pulse when a result (or div_zero) is valid
//   div_zero       last accepted DIV/DIVU had b == 0
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [WIDTH-1:0]   opnd_q,     opnd_d;
    logic               is_div_q,   is_div_d;
    logic               neg_lo_q,   neg_lo_d;
    logic               neg_hi_q,   neg_hi_d;
    logic [WIDTH-1:0]   hi_q,       hi_d;
    logic [WIDTH-1:0]   lo_q,       lo_d;
    logic               busy_q,     busy_d;
    logic               ready_q,    ready_d;
    logic               div_zero_q, div_zero_d;

    // Operand magnitudes; the unsigned view of |MIN_NEG| is already correct.
    logic             is_signed_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;

    assign is_signed_c = ~op[0];
    assign a_neg_c     = is_signed_c & a[WIDTH-1];
    assign b_neg_c     = is_signed_c & b[WIDTH-1];
    assign abs_a_c     = a_neg_c ? (~a + WIDTH'(1)) : a;
    assign abs_b_c     = b_neg_c ? (~b + WIDTH'(1)) : b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]   mul_sum_c;
    logic [ACC_W-1:0] mul_next_c;

    assign mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    // Restoring step: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic [ACC_W-1:0] div_next_c;

    assign div_shift_c = acc_q[ACC_W-1:WIDTH-1];
    assign div_diff_c  = div_shift_c - {1'b0, opnd_q};
    assign div_next_c  = div_diff_c[WIDTH]
                       ? {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                       : {div_diff_c[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results used in FIX.
    logic [ACC_W-1:0] prod_fix_c;
    logic [WIDTH-1:0] quot_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    assign prod_fix_c = neg_lo_q ? (~acc_q + ACC_W'(1)) : acc_q;
    assign quot_fix_c = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    assign rem_fix_c  = neg_hi_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op[1] && (b == '0)) begin
                        // Divide-by-zero completes immediately; hi/lo untouched.
                        div_zero_d = 1'b1;
                        ready_d    = 1'b1;
                    end else begin
                        div_zero_d = 1'b0;
                        busy_d     = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_CALC;
                        is_div_d   = op[1];
                        neg_lo_d   = a_neg_c ^ b_neg_c;
                        if (op[1]) begin
                            acc_d    = {WIDTH'(0), abs_a_c};
                            opnd_d   = abs_b_c;
                            neg_hi_d = a_neg_c;
                        end else begin
                            acc_d    = {WIDTH'(0), abs_b_c};
                            opnd_d   = abs_a_c;
                            neg_hi_d = 1'b0;
                        end
                    end
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next_c : mul_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix_c;
                    lo_d = quot_fix_c;
                end else begin
                    hi_d = prod_fix_c[ACC_W-1:WIDTH];
                    lo_d = prod_fix_c[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a scoreboard of expected hi/lo/div_zero/latency
// filled at issue time from a 64-bit reference model, checked when ready pulses.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;
    localparam int          LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             ready;
    logic             div_zero;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .ready    (ready),
        .div_zero (div_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          vectors = 0;
    int          errors  = 0;

    // Reference model; ph/pl are the held hi/lo for divide-by-zero.
    function automatic exp_t predict(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] ph, input logic [31:0] pl);
        exp_t        e;
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.dz  = 1'b0;
        e.lat = LAT;
        e.hi  = ph;
        e.lo  = pl;
        case (o)
            2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    e.dz  = 1'b1;
                    e.lat = 0;
                end else if (o == 2'b10) begin
                    q = 64'(sx / sy); r = 64'(sx % sy);
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Push the expectation, then present the request for exactly one edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e = predict(o, x, y, m_hi, m_lo);
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Bounded wait for ready, counting edges since the start edge and busy-high cycles.
    task automatic wait_ready(output int cyc, output int busy_cnt, output bit ok);
        cyc = -1; busy_cnt = 0; ok = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            if (ready) begin cyc = i; ok = 1'b1; break; end
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'h0)    begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        vectors++; if (lo !== 32'h0)    begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        vectors++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        vectors++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult_latency();
        int cyc; int bc; bit ok; exp_t e;
        issue(2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (!ok || cyc != 33) begin errors++; $display("FAIL mult_latency got=%0d exp=33", cyc); end
        vectors++; if (bc != 33) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_ready got=%b exp=0", busy); end
        vectors++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL mult_model got=%h%h exp=%h%h", hi, lo, e.hi, e.lo); end
        @(posedge clk); #1;
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got=%b exp=0", ready); end
    endtask

    task automatic test_arith_table();
        logic [1:0]  t_op [6];
        logic [31:0] t_a  [6];
        logic [31:0] t_b  [6];
        int cyc; int bc; bit ok; exp_t e;
        t_op = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'h8000_0000};
        t_b  = '{32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_ready(cyc, bc, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || cyc != e.lat) begin errors++; $display("FAIL arith%0d_latency got=%0d exp=%0d", i, cyc, e.lat); end
            vectors++;
            if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz)
                begin errors++; $display("FAIL arith%0d_result got=%h/%h/%b exp=%h/%h/%b", i, hi, lo, div_zero, e.hi, e.lo, e.dz); end
        end
        // Literal spot checks of the signed corner cases from the table above.
        vectors++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin errors++; $display("FAIL min_sq got=%h%h exp=4000000000000000", hi, lo); end
    endtask

    task automatic test_div_zero();
        int cyc; int bc; bit ok; exp_t e;
        issue(2'b00, 32'h0001_2345, 32'hFFFF_6789);
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL dz_preload got=%h/%h exp=%h/%h", hi, lo, e.hi, e.lo); end
        issue(2'b11, 32'hDEAD_BEEF, 32'h0);
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (!ok || cyc != 0) begin errors++; $display("FAIL dz_latency got=%0d exp=0", cyc); end
        vectors++; if (div_zero !== 1'b1 || busy !== 1'b0 || bc != 0) begin errors++; $display("FAIL dz_flags got dz=%b busy=%b bc=%0d exp dz=1 busy=0 bc=0", div_zero, busy, bc); end
        vectors++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL dz_hold got=%h/%h exp=%h/%h", hi, lo, e.hi, e.lo); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (div_zero !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL dz_sticky got dz=%b ready=%b exp dz=1 ready=0", div_zero, ready); end
        issue(2'b11, 32'd100, 32'd7);
        vectors++; if (div_zero !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dz_clear got dz=%b busy=%b exp dz=0 busy=1", div_zero, busy); end
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (!ok || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL divu_after_dz got=%h/%h exp=2/e", hi, lo); end
    endtask

    task automatic test_ignore_busy();
        int cyc; int bc; bit ok; int extra; exp_t e;
        issue(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h1111_1111;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (!ok || cyc != LAT - 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, LAT - 5); end
        vectors++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL ignore_result got=%h/%h exp=%h/%h", hi, lo, e.hi, e.lo); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready || busy) extra++;
        end
        vectors++; if (extra != 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int cyc; int bc; bit ok; exp_t e;
        issue(2'b00, 32'h0BAD_F00D, 32'h0000_0777);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
        vectors++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL midreset_busy got busy=%b ready=%b exp 0/0", busy, ready); end
        sb.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_ready(cyc, bc, ok);
        e = sb.pop_front();
        vectors++; if (!ok || cyc != LAT) begin errors++; $display("FAIL postreset_latency got=%0d exp=%0d", cyc, LAT); end
        vectors++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL postreset_result got=%h/%h exp=fffffffe/00000001", hi, lo); end
    endtask

    // Each new start lands in the cycle where the previous ready is high.
    task automatic test_back_to_back();
        int cyc; int bc; bit ok; exp_t e;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : 32'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : 32'($urandom));
            if (i == 3) begin o = 2'b10; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (i == 6) begin o = 2'b10; y = 32'h0; end
            issue(o, x, y);
            wait_ready(cyc, bc, ok);
            if (sb.size() == 0) begin
                vectors++; errors++; $display("FAIL b2b%0d_scoreboard_empty", i);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (!ok || cyc != e.lat) begin errors++; $display("FAIL b2b%0d_latency op=%0d got=%0d exp=%0d", i, o, cyc, e.lat); end
                vectors++;
                if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz)
                    begin errors++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h got=%h/%h/%b exp=%h/%h/%b", i, o, x, y, hi, lo, div_zero, e.hi, e.lo, e.dz); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_latency();
        test_arith_table();
        test_div_zero();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
